instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the single-cycle datapath.
- Takes the current PC from the datapath and fetches the word from an instruction memory that has variable latency and a valid/ready handshake.
- Presents the word on the datapath's instruction input for exactly one execute cycle.
- Drives pc_advance, which the datapath uses as the PC register enable, so the datapath stalls while a fetch is outstanding.

Parameters:
TIMEOUT, 15, maximum WAIT-state cycles without a response before fetch_error; legal range 1..255.
RESET_INSTR, 32'h0000_0000, value of instruction after reset (MIPS NOP).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
pc  input  32  current PC from the datapath PC register
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  instruction memory accepts request
imem_req_addr  output  32  byte address of the requested word
imem_resp_valid  input  1  response data valid, one-cycle pulse
imem_resp_data  input  32  fetched instruction word
instruction  output  32  instruction to the datapath/control
instr_valid  output  1  instruction is live this cycle
pc_advance  output  1  PC register enable for this edge
fetch_error  output  1  sticky error (misaligned PC or timeout)
fetch_count  output  32  number of instructions delivered since reset

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, instruction=RESET_INSTR.
  - instr_valid, pc_advance, imem_req_valid and fetch_error all 0; fetch_count=0; timeout counter=0.
  - Reset takes effect immediately, including mid-REQ or mid-WAIT.
  - Any response arriving outside WAIT is ignored.
  - The instruction memory shares this reset, so no stale response crosses reset.
- States: IDLE, REQ, WAIT, VALID, ERROR.
- IDLE:
  - Entered on reset only.
  - Unconditional transition to REQ on the first clock edge after reset release.
- REQ:
  - imem_req_valid=1; imem_req_addr=pc (combinational; pc is stable because pc_advance=0).
  - If pc[1:0]!=0: imem_req_valid=0 and next state is ERROR.
  - Otherwise, on imem_req_valid & imem_req_ready at the edge: go to WAIT and clear the timeout counter.
  - While imem_req_ready=0, stay in REQ; address and valid hold. There is no timeout in REQ.
- WAIT:
  - imem_req_valid=0.
  - imem_resp_valid=1: capture imem_resp_data into instruction and go to VALID.
  - Else: counter += 1. When the counter reaches TIMEOUT, go to ERROR.
  - A response arriving in the cycle the counter would reach TIMEOUT wins: capture it, no error.
  - The memory guarantees latency >=1 cycle after acceptance; a response in the acceptance cycle is not sampled.
- VALID:
  - instr_valid=1 and pc_advance=1 for exactly one cycle; the datapath PC loads next_pc at this edge.
  - fetch_count += 1 (wraps at 2^32).
  - Next state is REQ, which uses the updated pc.
- ERROR:
  - fetch_error=1; instr_valid, pc_advance and imem_req_valid are all 0.
  - instruction holds its last value.
  - Sticky until reset.
- instruction holds its last captured value in every state except the capture edge; it is only meaningful when instr_valid=1.
- Throughput: at best one instruction per 3 cycles (REQ with ready=1, WAIT with latency 1, VALID).
- All outputs are registered except imem_req_valid, imem_req_addr, instr_valid and pc_advance, which decode from registered state (plus pc for the address and the misalignment check).

Test Plan:
1. Release reset with pc=0x0000_0000, ready=1, response 1 cycle after acceptance with data 0x2008_0005 -> imem_req_addr=0 in REQ; instruction=0x2008_0005 with instr_valid=pc_advance=1 in the 3rd cycle after REQ entry; fetch_count=1.
2. Latency 5 on pc=0x0000_0004 (data 0x0109_5020) -> 5 WAIT cycles with pc_advance=0 and instruction unchanged, then a single VALID cycle; no error.
3. imem_req_ready held 0 for 4 cycles in REQ -> imem_req_valid=1 and imem_req_addr stable for all 4 cycles, handshake on the 5th; no timeout.
4. pc=0x0000_0006 in REQ -> no request issued; fetch_error=1 the next cycle and it persists; instr_valid stays 0 even if resp_valid is pulsed.
5. TIMEOUT=15, no response -> fetch_error asserts after 15 WAIT cycles. Repeat with the response on WAIT cycle 15 -> captured, fetch_error=0.
6. Deassert reset to 0 mid-WAIT -> all outputs return to reset values in the same cycle. After release, fetch restarts from IDLE; fetch_count=0 and instruction=RESET_INSTR until the next capture.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage in front of the single-cycle datapath: issues one request per PC to a
// variable-latency instruction memory and presents the word for exactly one execute cycle.
module instr_fetch_unit #(
  parameter int unsigned TIMEOUT     = 15,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic        pc_advance,
  output logic        fetch_error,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_ERROR
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        error_q, error_d;
  logic        misaligned;
  logic [7:0]  timer_inc;

  assign misaligned = |pc[1:0];
  assign timer_inc  = timer_q + 8'd1;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    instr_d        = instr_q;
    count_d        = count_q;
    error_d        = error_q;
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    pc_advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (misaligned) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) begin
            state_d = S_WAIT;
            timer_d = 8'd0;
          end
        end
      end

      S_WAIT: begin
        // A response in the cycle that would expire the timer still wins.
        if (imem_resp_valid) begin
          instr_d = imem_resp_data;
          state_d = S_VALID;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TIMEOUT_C) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end

      S_VALID: begin
        instr_valid = 1'b1;
        pc_advance  = 1'b1;
        count_d     = count_q + 32'd1;
        state_d     = S_REQ;
      end

      S_ERROR: begin
        state_d = S_ERROR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // NOTE: the instruction register is reset as well because its reset value
  // (a NOP) is visible to the datapath before the first capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= 8'd0;
      instr_q <= RESET_INSTR;
      count_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      instr_q <= instr_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign imem_req_addr = pc;
  assign instruction   = instr_q;
  assign fetch_count   = count_q;
  assign fetch_error   = error_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit: a transaction-level model predicts
// cycle timing, delivered words and the delivery count for each fetch.
module tb_instr_fetch_unit;

  localparam int unsigned TB_TIMEOUT     = 15;
  localparam logic [31:0] TB_RESET_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        pc_advance;
  logic        fetch_error;
  logic [31:0] fetch_count;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_instr = TB_RESET_INSTR;
  logic [31:0] exp_count = 32'd0;

  instr_fetch_unit #(
    .TIMEOUT    (TB_TIMEOUT),
    .RESET_INSTR(TB_RESET_INSTR)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .pc_advance     (pc_advance),
    .fetch_error    (fetch_error),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ":req_valid"},   32'(imem_req_valid), 32'd0);
    check({tag, ":instr_valid"}, 32'(instr_valid),    32'd0);
    check({tag, ":pc_advance"},  32'(pc_advance),     32'd0);
    check({tag, ":fetch_error"}, 32'(fetch_error),    32'd0);
    check({tag, ":fetch_count"}, fetch_count,         32'd0);
    check({tag, ":instruction"}, instruction,         TB_RESET_INSTR);
  endtask

  // Called at a falling edge; leaves the bench at the falling edge of the first REQ cycle.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check({tag, ":idle_no_req"}, 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    exp_instr = TB_RESET_INSTR;
    exp_count = 32'd0;
  endtask

  // One fetch transaction, starting at the falling edge of a REQ cycle.
  // rdy_delay: REQ cycles with ready low; lat: WAIT cycle (1-based) carrying the response.
  task automatic fetch(input string tag, input logic [31:0] addr, input int rdy_delay,
                       input int lat, input logic [31:0] data);
    pc = addr;
    for (int i = 0; i < rdy_delay; i++) begin
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'($urandom_range(0, 1));
      imem_resp_data  = $urandom();
      #1;
      check({tag, ":stall_req_valid"}, 32'(imem_req_valid), 32'd1);
      check({tag, ":stall_addr"},      imem_req_addr,       addr);
      check({tag, ":stall_advance"},   32'(pc_advance),     32'd0);
      @(negedge clk);
    end
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    #1;
    check({tag, ":req_valid"}, 32'(imem_req_valid), 32'd1);
    check({tag, ":req_addr"},  imem_req_addr,       addr);
    @(negedge clk);
    imem_req_ready = 1'($urandom_range(0, 1));
    for (int w = 1; w <= lat; w++) begin
      imem_resp_valid = (w == lat);
      imem_resp_data  = (w == lat) ? data : $urandom();
      #1;
      check({tag, ":wait_instr_valid"}, 32'(instr_valid),    32'd0);
      check({tag, ":wait_advance"},     32'(pc_advance),     32'd0);
      check({tag, ":wait_req_valid"},   32'(imem_req_valid), 32'd0);
      check({tag, ":wait_instr_hold"},  instruction,         exp_instr);
      check({tag, ":wait_no_error"},    32'(fetch_error),    32'd0);
      @(negedge clk);
    end
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom();
    imem_req_ready  = 1'b0;
    #1;
    check({tag, ":instruction"}, instruction,       data);
    check({tag, ":instr_valid"}, 32'(instr_valid),  32'd1);
    check({tag, ":pc_advance"},  32'(pc_advance),   32'd1);
    check({tag, ":count_pre"},   fetch_count,       exp_count);
    exp_instr = data;
    exp_count = exp_count + 32'd1;
    @(negedge clk);
    #1;
    check({tag, ":count_post"},  fetch_count,      exp_count);
    check({tag, ":one_shot"},    32'(instr_valid), 32'd0);
    check({tag, ":no_error"},    32'(fetch_error), 32'd0);
  endtask

  initial begin
    logic [31:0] next_pc;

    // Power-on reset
    reset = 1'b0;
    #2;
    check_reset_vals("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("por:idle_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);

    // Basic fetch, long latency, ready stall, response on the last legal WAIT cycle
    fetch("t1_basic",   32'h0000_0000, 0, 1, 32'h2008_0005);
    fetch("t2_lat5",    32'h0000_0004, 0, 5, 32'h0109_5020);
    fetch("t3_stall",   32'h0000_0008, 4, 2, 32'hDEAD_BEEF);
    fetch("t5_win",     32'h0000_000C, 0, TB_TIMEOUT, 32'h1234_5678);

    // Randomized fetch stream: sequential PCs with occasional aligned branch targets
    next_pc = 32'h0000_0010;
    for (int n = 0; n < 40; n++) begin
      fetch("rand", next_pc, $urandom_range(0, 3), $urandom_range(1, TB_TIMEOUT), $urandom());
      if ($urandom_range(0, 3) == 0) next_pc = $urandom() & 32'hFFFF_FFFC;
      else                           next_pc = next_pc + 32'd4;
    end

    // Timeout: no response for TIMEOUT WAIT cycles
    pc = 32'h0000_0100;
    imem_req_ready = 1'b1;
    #1;
    check("t5_to:req_valid", 32'(imem_req_valid), 32'd1);
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int w = 1; w <= int'(TB_TIMEOUT); w++) begin
      #1;
      check("t5_to:wait_no_error", 32'(fetch_error), 32'd0);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      imem_resp_valid = (k == 1);
      imem_resp_data  = $urandom();
      #1;
      check("t5_to:error",       32'(fetch_error),    32'd1);
      check("t5_to:instr_valid", 32'(instr_valid),    32'd0);
      check("t5_to:req_valid",   32'(imem_req_valid), 32'd0);
      check("t5_to:instr_hold",  instruction,         exp_instr);
      @(negedge clk);
    end
    do_reset("rst_after_timeout");

    // Misaligned PC: no request, sticky error, responses ignored
    pc = 32'h0000_0006;
    imem_req_ready = 1'b1;
    #1;
    check("t4_mis:no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    pc = 32'h0000_0008;
    for (int k = 0; k < 5; k++) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = $urandom();
      #1;
      check("t4_mis:error",       32'(fetch_error),    32'd1);
      check("t4_mis:instr_valid", 32'(instr_valid),    32'd0);
      check("t4_mis:advance",     32'(pc_advance),     32'd0);
      check("t4_mis:req_valid",   32'(imem_req_valid), 32'd0);
      check("t4_mis:instr_hold",  instruction,         exp_instr);
      @(negedge clk);
    end
    imem_req_ready = 1'b0;
    do_reset("rst_after_misalign");

    // Reset asserted mid-WAIT after a successful fetch
    fetch("t6_pre", 32'h0000_0200, 1, 3, 32'hCAFE_F00D);
    pc = 32'h0000_0204;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    @(negedge clk);
    do_reset("t6_midwait");
    #1;
    check("t6:instr_after_release", instruction, TB_RESET_INSTR);
    check("t6:count_after_release", fetch_count, 32'd0);
    fetch("t6_restart", 32'h0000_0204, 0, 1, 32'h0000_0BAD);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
